// File: rtl/aead_crypt_core.sv
// -----------------------------------------------------------------------------
// aead_crypt_core
//
// Iterative 128-bit authenticated-encryption core. A 32-bit-word ARX
// permutation keyed from a 448-bit key runs one round per clock through the
// INIT, AD, MSG and FIN phases. The core then emits the ciphertext (encrypt)
// or the plaintext (decrypt) together with a tag. In decrypt mode, a tag
// mismatch raises failure and forces DOUT to zero.
//
// Optional feature macro: AEAD_AD_PHASE_EN
//   defined   : the AD phase absorbs A (latency 4*ROUNDS)
//   undefined : A is ignored and the AD phase is skipped (latency 3*ROUNDS)
//
// Parameters:
//   ROUNDS  permutation rounds per phase (1..64)
//   TAG_W   tag width in bits (1..128)
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   start    level request, sampled in IDLE
//   MODE     0 = encrypt, 1 = decrypt (sampled with start)
//   K        448-bit key, word i = K[447-32i -: 32]
//   S        128-bit seed / initial state
//   NONCE    128-bit nonce
//   A        128-bit associated data
//   DIN      plaintext (encrypt) or ciphertext (decrypt)
//   TAG_IN   expected tag (decrypt only)
//   DOUT     ciphertext (encrypt) or plaintext (decrypt)
//   TAG      computed tag
//   done     result valid
//   failure  decrypt tag mismatch
// -----------------------------------------------------------------------------
module aead_crypt_core #(
   parameter int ROUNDS = 12,
   parameter int TAG_W  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             MODE,
   input  logic [447:0]     K,
   input  logic [127:0]     S,
   input  logic [127:0]     NONCE,
   input  logic [127:0]     A,
   input  logic [127:0]     DIN,
   input  logic [TAG_W-1:0] TAG_IN,
   output logic [127:0]     DOUT,
   output logic [TAG_W-1:0] TAG,
   output logic             done,
   output logic             failure
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_AD,
      ST_MSG,
      ST_FIN,
      ST_DONE
   } fsm_t;

   fsm_t              fsm_q;
   logic [127:0]      state_q;
   logic [127:0]      dout_q;
   logic [5:0]        r_q;
   logic [3:0]        k_q;      // r mod 14, tracked incrementally
   logic              mode_q;

   logic [31:0]       kw [14];
   logic [1:0]        ph;
   logic [127:0]      s;
   logic              last;
   logic [127:0]      msg_dout;
   logic [127:0]      msg_state;
   logic [TAG_W-1:0]  tag_calc;
   logic              mismatch;

`ifndef AEAD_AD_PHASE_EN
   logic              unused_a;
   assign unused_a = ^A;
`endif

   for (genvar i = 0; i < 14; i++) begin : g_kw
      assign kw[i] = K[447-32*i -: 32];
   end

   function automatic logic [31:0] rotl16(input logic [31:0] x);
      return {x[15:0], x[31:16]};
   endfunction

   function automatic logic [31:0] rotl12(input logic [31:0] x);
      return {x[19:0], x[31:20]};
   endfunction

   // One ARX round on the current state.
   function automatic logic [127:0] round_f(input logic [127:0] st,
                                            input logic [31:0]  key_word,
                                            input logic [1:0]   phase,
                                            input logic [5:0]   rnd);
      logic [31:0] x0, x1, x2, x3;
      x0 = st[127:96];
      x1 = st[95:64];
      x2 = st[63:32];
      x3 = st[31:0];
      x0 = x0 + x1;
      x3 = rotl16(x3 ^ x0);
      x2 = x2 + x3;
      x1 = rotl12(x1 ^ x2);
      x0 = x0 ^ key_word ^ {24'h0, phase, rnd};
      return {x0, x1, x2, x3};
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      ph = 2'd0;
      case (fsm_q)
         ST_AD:   ph = 2'd1;
         ST_MSG:  ph = 2'd2;
         ST_FIN:  ph = 2'd3;
         default: ph = 2'd0;
      endcase
   end

   assign s    = round_f(state_q, kw[k_q], ph, r_q);
   assign last = (r_q == 6'(ROUNDS - 1));

   // Both modes output s ^ DIN. The state absorbs the ciphertext: s ^ DIN
   // when encrypting, DIN itself when decrypting.
   assign msg_dout  = s ^ DIN;
   assign msg_state = mode_q ? DIN : (s ^ DIN);

   assign tag_calc = s[127 -: TAG_W];
   assign mismatch = mode_q & (tag_calc != TAG_IN);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         dout_q  <= '0;
         r_q     <= '0;
         k_q     <= '0;
         mode_q  <= 1'b0;
         DOUT    <= '0;
         TAG     <= '0;
         done    <= 1'b0;
         failure <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= S ^ NONCE;
                  r_q     <= '0;
                  k_q     <= '0;
                  mode_q  <= MODE;
                  fsm_q   <= ST_INIT;
               end
            end

            ST_INIT, ST_AD, ST_MSG, ST_FIN: begin
               if (!last) begin
                  state_q <= s;
                  r_q     <= r_q + 6'd1;
                  k_q     <= (k_q == 4'd13) ? 4'd0 : k_q + 4'd1;
               end else begin
                  r_q <= '0;
                  k_q <= '0;
                  case (fsm_q)
                     ST_INIT: begin
`ifdef AEAD_AD_PHASE_EN
                        state_q <= s ^ A;
                        fsm_q   <= ST_AD;
`else
                        dout_q  <= msg_dout;
                        state_q <= msg_state;
                        fsm_q   <= ST_MSG;
`endif
                     end
                     ST_AD: begin
                        dout_q  <= msg_dout;
                        state_q <= msg_state;
                        fsm_q   <= ST_MSG;
                     end
                     ST_MSG: begin
                        state_q <= s ^ K[127:0];
                        fsm_q   <= ST_FIN;
                     end
                     default: begin
                        state_q <= s;
                        TAG     <= tag_calc;
                        failure <= mismatch;
                        DOUT    <= mismatch ? '0 : dout_q;
                        done    <= 1'b1;
                        fsm_q   <= ST_DONE;
                     end
                  endcase
               end
            end

            ST_DONE: begin
               // Results hold while start stays high. DOUT and TAG also
               // persist after the handshake completes.
               if (!start) begin
                  done    <= 1'b0;
                  failure <= 1'b0;
                  fsm_q   <= ST_IDLE;
               end
            end

            default: fsm_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aead_crypt_core.sv
// -----------------------------------------------------------------------------
// tb_aead_crypt_core
//
// Directed self-checking bench for aead_crypt_core. The bench covers reset
// values, encrypt latency and result, the hold/release handshake, restart
// repeatability, an asynchronous reset in mid-INIT, the decrypt round trip,
// two tamper cases and insensitivity to A when the AD phase is compiled out.
// Expected DOUT/TAG values come from a behavioural model of the permutation
// kept inside the bench.
// -----------------------------------------------------------------------------
module tb_aead_crypt_core;

   localparam int ROUNDS = 12;
   localparam int TAG_W  = 1;
`ifdef AEAD_AD_PHASE_EN
   localparam int LAT = 4 * ROUNDS;
`else
   localparam int LAT = 3 * ROUNDS;
`endif

   localparam logic [447:0] KEY_V   = 448'h75686577667569686875666f656969;
   localparam logic [127:0] SEED_V  = 128'h726f6265727420697320636f6f6c2021;
   localparam logic [127:0] NONCE_V = 128'h64646f6e277420726561642074686973;
   localparam logic [127:0] PT_V    = 128'h646e2774206465637279707420746873;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             MODE;
   logic [447:0]     K;
   logic [127:0]     S;
   logic [127:0]     NONCE;
   logic [127:0]     A;
   logic [127:0]     DIN;
   logic [TAG_W-1:0] TAG_IN;
   logic [127:0]     DOUT;
   logic [TAG_W-1:0] TAG;
   logic             done;
   logic             failure;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   aead_crypt_core #(.ROUNDS(ROUNDS), .TAG_W(TAG_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .MODE    (MODE),
      .K       (K),
      .S       (S),
      .NONCE   (NONCE),
      .A       (A),
      .DIN     (DIN),
      .TAG_IN  (TAG_IN),
      .DOUT    (DOUT),
      .TAG     (TAG),
      .done    (done),
      .failure (failure)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] key_word(input int i);
      logic [447:0] sh;
      sh = KEY_V >> (32 * (13 - i));
      return sh[31:0];
   endfunction

   function automatic logic [127:0] perm(input logic [127:0] st, input logic [1:0] ph);
      logic [31:0] w [4];
      for (int i = 0; i < 4; i++) w[i] = st[127-32*i -: 32];
      for (int r = 0; r < ROUNDS; r++) begin
         w[0] = w[0] + w[1];
         w[3] = rotl(w[3] ^ w[0], 16);
         w[2] = w[2] + w[3];
         w[1] = rotl(w[1] ^ w[2], 12);
         w[0] = w[0] ^ key_word(r % 14) ^ {24'h0, ph, 6'(r)};
      end
      return {w[0], w[1], w[2], w[3]};
   endfunction

   task automatic model(input bit m, input logic [127:0] din, input logic [TAG_W-1:0] tin,
                        input logic [127:0] a_v, output logic [127:0] dout_e,
                        output logic [TAG_W-1:0] tag_e, output bit fail_e);
      logic [127:0] st, ct, pt, res;
      st = perm(SEED_V ^ NONCE_V, 2'd0);
`ifdef AEAD_AD_PHASE_EN
      st = perm(st ^ a_v, 2'd1);
`endif
      if (m) begin
         ct  = din;
         pt  = st ^ din;
         res = pt;
      end else begin
         pt  = din;
         ct  = st ^ din;
         res = ct;
      end
      st     = perm(st ^ pt, 2'd2);
      st     = perm(st ^ KEY_V[127:0], 2'd3);
      tag_e  = st[127 -: TAG_W];
      fail_e = m && (tag_e != tin);
      dout_e = fail_e ? 128'h0 : res;
   endtask

   // ---------------- stimulus helpers ----------------
   // Raise start, then count rising edges after the sampling edge until done.
   task automatic run(input bit m, output int lat);
      @(negedge clk);
      MODE  = m;
      start = 1'b1;
      @(posedge clk);
      lat = 0;
      while (lat < 300) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) break;
      end
   endtask

   task automatic drop_start(input string tag);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_done_clr"}, 128'(done), 128'd0);
      check({tag, "_fail_clr"}, 128'(failure), 128'd0);
   endtask

   initial begin
      logic [127:0]     ct_ref, exp_dout, held_dout;
      logic [TAG_W-1:0] tag_ref, exp_tag, held_tag;
      bit               exp_fail;
      int               lat;
      bit               stable, seen;

      rst    = 1'b0;
      start  = 1'b0;
      MODE   = 1'b0;
      K      = KEY_V;
      S      = SEED_V;
      NONCE  = NONCE_V;
      A      = NONCE_V;
      DIN    = PT_V;
      TAG_IN = '0;

      #12;
      check("rst_dout", DOUT, 128'd0);
      check("rst_tag", 128'(TAG), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_fail", 128'(failure), 128'd0);
      @(negedge clk);
      rst = 1'b1;

      // Encrypt: latency and golden result.
      model(1'b0, PT_V, '0, NONCE_V, ct_ref, tag_ref, exp_fail);
      run(1'b0, lat);
      check("enc_latency", 128'(lat), 128'(LAT));
      check("enc_dout", DOUT, ct_ref);
      check("enc_tag", 128'(TAG), 128'(tag_ref));
      check("enc_fail", 128'(failure), 128'd0);

      // Hold start high: all outputs stay frozen.
      stable = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (DOUT !== ct_ref || TAG !== tag_ref || done !== 1'b1 || failure !== 1'b0)
            stable = 1'b0;
      end
      check("hold_stable", 128'(stable), 128'd1);
      drop_start("enc");
      check("enc_dout_kept", DOUT, ct_ref);
      check("enc_tag_kept", 128'(TAG), 128'(tag_ref));

      // A restart with the same inputs must give an identical result.
      run(1'b0, lat);
      check("restart_latency", 128'(lat), 128'(LAT));
      check("restart_dout", DOUT, ct_ref);
      check("restart_tag", 128'(TAG), 128'(tag_ref));
      drop_start("restart");

      // Assert reset asynchronously in mid-INIT. Outputs clear immediately.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      rst   = 1'b0;
      start = 1'b0;
      #1;
      check("midrst_dout", DOUT, 128'd0);
      check("midrst_tag", 128'(TAG), 128'd0);
      check("midrst_done", 128'(done), 128'd0);
      check("midrst_fail", 128'(failure), 128'd0);
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      repeat (LAT + 20) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("midrst_no_done", 128'(seen), 128'd0);

      // Decrypt round trip.
      DIN    = ct_ref;
      TAG_IN = tag_ref;
      run(1'b1, lat);
      check("dec_latency", 128'(lat), 128'(LAT));
      check("dec_dout", DOUT, PT_V);
      check("dec_fail", 128'(failure), 128'd0);
      check("dec_tag", 128'(TAG), 128'(tag_ref));
      drop_start("dec");

      // Tamper with the inverted tag: mismatch is certain.
      TAG_IN = ~tag_ref;
      run(1'b1, lat);
      check("tamp_tag_fail", 128'(failure), 128'd1);
      check("tamp_tag_dout", DOUT, 128'd0);
      drop_start("tamp_tag");

      // Tamper with ciphertext bit 0. The model decides whether the
      // short tag still matches.
      DIN    = ct_ref ^ 128'd1;
      TAG_IN = tag_ref;
      model(1'b1, DIN, TAG_IN, NONCE_V, exp_dout, exp_tag, exp_fail);
      run(1'b1, lat);
      check("tamp_ct_fail", 128'(failure), 128'(exp_fail));
      check("tamp_ct_dout", DOUT, exp_dout);
      check("tamp_ct_tag", 128'(TAG), 128'(exp_tag));
      drop_start("tamp_ct");

      // Vary A. With the AD phase compiled out, the result is unchanged.
      A   = 128'h0123456789abcdef_fedcba9876543210;
      DIN = PT_V;
      model(1'b0, PT_V, '0, A, exp_dout, exp_tag, exp_fail);
`ifndef AEAD_AD_PHASE_EN
      check("a_model_indep", exp_dout, ct_ref);
`endif
      run(1'b0, lat);
      check("avar_latency", 128'(lat), 128'(LAT));
      check("avar_dout", DOUT, exp_dout);
      check("avar_tag", 128'(TAG), 128'(exp_tag));
      drop_start("avar");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/aead_crypt_core.md
Name: aead_crypt_core

Overview:
- Iterative 128-bit authenticated-encryption core. One instance performs either encryption or decryption, selected by MODE.
- The state is processed by a 32-bit-word ARX permutation keyed from a 448-bit key, one round per clock.
- The core absorbs seed, nonce and associated data, then encrypts or decrypts one 128-bit block and produces a tag.
- In decrypt mode the core checks the tag and suppresses the output on mismatch. It sits between the key/data registers and the system bus.

Parameters:
- ROUNDS, 12: permutation rounds per phase. Legal range 1..64.
- TAG_W, 1: tag width in bits. Legal range 1..128.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: level request; sampled in IDLE.
- MODE, in, 1: 0 = encrypt, 1 = decrypt. Sampled with start.
- K, in, 448: key. Word kw(i) = K[447-32i -: 32], for i = 0..13.
- S, in, 128: seed/initial state.
- NONCE, in, 128: nonce.
- A, in, 128: associated data.
- DIN, in, 128: plaintext in encrypt mode, ciphertext in decrypt mode.
- TAG_IN, in, TAG_W: expected tag; used only in decrypt mode.
- DOUT, out, 128: ciphertext in encrypt mode, plaintext in decrypt mode.
- TAG, out, TAG_W: computed tag.
- done, out, 1: result valid.
- failure, out, 1: decrypt tag mismatch.

Behaviour:
- Reset (rst = 0, asynchronous): FSM goes to IDLE. DOUT, TAG, done and failure are 0. Internal state and round counter are 0. Reset mid-operation aborts the run and no result is produced.
- Inputs K, S, NONCE, A, DIN, TAG_IN and MODE must be held stable from start until done.
- FSM states:
  - IDLE: when start = 1, state <= S ^ NONCE, r <= 0, go to INIT.
  - INIT, AD, MSG, FIN: one round per cycle for r = 0..ROUNDS-1.
  - DONE: hold all outputs.
- Round (words x0 = state[127:96] .. x3 = state[31:0]; + is mod 2^32; rotl is rotate-left):
  1. x0 += x1
  2. x3 = rotl(x3 ^ x0, 16)
  3. x2 += x3
  4. x1 = rotl(x1 ^ x2, 12)
  5. x0 ^= kw(r mod 14) ^ {24'h0, ph[1:0], r[5:0]}
  - ph values: INIT = 0, AD = 1, MSG = 2, FIN = 3.
- End-of-phase edge (r = ROUNDS-1): let s = round(state).
  - INIT -> AD: state <= s ^ A.
  - AD -> MSG:
    - Encrypt: ct = s ^ DIN; pt = DIN; dout_q <= ct.
    - Decrypt: ct = DIN; pt = s ^ DIN; dout_q <= pt.
    - state <= s ^ pt, which equals ct in both modes.
  - MSG -> FIN: state <= s ^ K[127:0].
  - FIN -> DONE:
    - TAG <= s[127 -: TAG_W].
    - failure <= MODE & (s[127 -: TAG_W] != TAG_IN).
    - DOUT <= (MODE & mismatch) ? 0 : dout_q.
    - done <= 1.
- Latency: done rises on the 4·ROUNDS-th rising edge after the start-sampling edge (48 for ROUNDS = 12).
- DONE exit:
  - done, DOUT, TAG and failure hold while start = 1.
  - When start = 0: go to IDLE; done and failure clear the same edge; DOUT and TAG keep their last values.
- start toggled while busy is ignored. A new run requires start = 0 for at least one cycle in IDLE or DONE.
- In encrypt mode failure is always 0.

Optional Feature:
- Macro AEAD_AD_PHASE_EN.
- Defined: AD phase present as described.
- Undefined:
  - A is ignored and the AD phase is skipped.
  - INIT end edge performs the MSG injection using s from INIT.
  - Latency is 3·ROUNDS.
  - The ph encoding is unchanged.

Test Plan:
- Reset: rst = 0 asynchronously mid-INIT -> DOUT = TAG = done = failure = 0 immediately; no done afterwards until a new start.
- Latency: encrypt, K = 448'h75686577667569686875666f656969, S = 128'h726f6265727420697320636f6f6c2021, NONCE = A = 128'h64646f6e277420726561642074686973, DIN = 128'h646e2774206465637279707420746873, start = 1 -> done exactly 48 edges later; DOUT matches the golden C model.
- Round trip: decrypt with DIN = previous DOUT and TAG_IN = previous TAG -> DOUT = 128'h646e2774206465637279707420746873, failure = 0, done after 48 edges.
- Tamper: same decrypt with DIN bit 0 flipped (or TAG_IN inverted when TAG_W = 1 and the tag differs) -> failure = 1, DOUT = 0.
- Handshake: hold start = 1 after done -> outputs stable for 20 cycles; drop start -> done = 0 next edge; restart -> identical result.
- Macro off: same encrypt vector -> done after 36 edges; DOUT unchanged when A is varied.
